// File: rtl/sha256_digest_writer.sv
// Digest write-back: buffers finished SHA-256 digests in a small FIFO and streams
// them word by word into word-addressed memory from a latched base address.
//   state    | meaning
//   ST_IDLE  | waiting for start; done is high
//   ST_RUN   | accepting digests and writing one word per cycle while the FIFO holds data
//   ST_DRAIN | last word issued; memory captures it on the edge leaving this state
module sha256_digest_writer #(
  parameter int DEPTH            = 4,
  parameter int WORDS_PER_RESULT = 8,
  parameter int NUM_RESULTS      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] output_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] h_in0,
  input  logic [31:0] h_in1,
  input  logic [31:0] h_in2,
  input  logic [31:0] h_in3,
  input  logic [31:0] h_in4,
  input  logic [31:0] h_in5,
  input  logic [31:0] h_in6,
  input  logic [31:0] h_in7,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_RESULTS + 1);

  localparam logic [2:0]       LAST_WORD = 3'(WORDS_PER_RESULT - 1);
  localparam logic [CNT_W-1:0] LAST_RES  = CNT_W'(NUM_RESULTS - 1);
  localparam logic [CNT_W-1:0] NUM_RES   = CNT_W'(NUM_RESULTS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [15:0]      WPR_16    = 16'(WORDS_PER_RESULT);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic [2:0]       word_q, word_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;

  logic [255:0]     fifo_mem [DEPTH];
  logic [255:0]     head;
  logic [31:0]      head_word;
  logic             push;
  logic             pop;

  assign in_ready = (state_q == ST_RUN) && (count_q < FIFO_FULL) && (acc_q < NUM_RES);
  assign push     = in_valid && in_ready;
  assign head      = fifo_mem[rd_ptr_q];
  assign head_word = head[{word_q, 5'd0} +: 32];

  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;
  assign done           = (state_q == ST_IDLE);

  // Digest storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {h_in7, h_in6, h_in5, h_in4, h_in3, h_in2, h_in1, h_in0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    acc_d      = acc_q;
    res_d      = res_q;
    word_d     = word_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = output_addr;
          acc_d    = '0;
          res_d    = '0;
          word_d   = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          acc_d    = acc_q + CNT_ONE;
        end
        if (count_q != '0) begin
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + 16'(res_q) * WPR_16 + 16'(word_q);
          mem_data_d = head_word;
          if (word_q == LAST_WORD) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            word_d   = '0;
            res_d    = res_q + CNT_ONE;
            if (res_q == LAST_RES) begin
              state_d = ST_DRAIN;
            end
          end else begin
            word_d = word_q + 3'd1;
          end
        end
        // Push is gated on the start-of-cycle count, so a pop never frees room for the same cycle.
        case ({push, pop})
          2'b10:   count_d = count_q + FCNT_ONE;
          2'b01:   count_d = count_q - FCNT_ONE;
          default: count_d = count_q;
        endcase
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_digest_writer.sv
// Scoreboard bench: accepted digests expand into expected (addr, data) writes in a queue;
// a monitor pops and compares every memory write. Two instances cover full and bitcoin modes.
module tb_sha256_digest_writer;

  localparam int NA = 6;
  localparam int WA = 8;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        start_a, valid_a, ready_a, mclk_a, we_a, done_a;
  logic [15:0] addr_a, maddr_a;
  logic [31:0] mdata_a;
  logic [31:0] h_a [8];

  logic        start_b, valid_b, ready_b, mclk_b, we_b, done_b;
  logic [15:0] addr_b, maddr_b;
  logic [31:0] mdata_b;
  logic [31:0] h_b [8];

  sha256_digest_writer #(.DEPTH(4), .WORDS_PER_RESULT(WA), .NUM_RESULTS(NA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .output_addr(addr_a),
    .in_valid(valid_a), .in_ready(ready_a),
    .h_in0(h_a[0]), .h_in1(h_a[1]), .h_in2(h_a[2]), .h_in3(h_a[3]),
    .h_in4(h_a[4]), .h_in5(h_a[5]), .h_in6(h_a[6]), .h_in7(h_a[7]),
    .mem_clk(mclk_a), .mem_we(we_a), .mem_addr(maddr_a), .mem_write_data(mdata_a),
    .done(done_a)
  );

  sha256_digest_writer #(.DEPTH(4), .WORDS_PER_RESULT(1), .NUM_RESULTS(NB)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .output_addr(addr_b),
    .in_valid(valid_b), .in_ready(ready_b),
    .h_in0(h_b[0]), .h_in1(h_b[1]), .h_in2(h_b[2]), .h_in3(h_b[3]),
    .h_in4(h_b[4]), .h_in5(h_b[5]), .h_in6(h_b[6]), .h_in7(h_b[7]),
    .mem_clk(mclk_b), .mem_we(we_b), .mem_addr(maddr_b), .mem_write_data(mdata_b),
    .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: run base, digests accepted, expected writes, writes observed.
  logic [15:0] base_a, base_b;
  int          acc_a = 0, acc_b = 0;
  int          wr_a = 0, wr_b = 0;
  logic [47:0] q_a [$];
  logic [47:0] q_b [$];
  bit          rnd_a = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset_n && valid_a && ready_a) begin
      chk("accept_limit_a", 48'(acc_a < NA), 48'd1);
      for (int j = 0; j < WA; j++) begin
        q_a.push_back({base_a + 16'(acc_a * WA + j), h_a[j]});
      end
      acc_a++;
    end
    if (reset_n && valid_b && ready_b) begin
      chk("accept_limit_b", 48'(acc_b < NB), 48'd1);
      q_b.push_back({base_b + 16'(acc_b), 32'hA000_0000 + 32'(acc_b)});
      acc_b++;
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (reset_n && we_a) begin
      wr_a++;
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_a_unexpected: got %0h:%0h expected none", maddr_a, mdata_a);
      end else begin
        e = q_a.pop_front();
        chk("write_a", {maddr_a, mdata_a}, e);
      end
    end
    if (reset_n && we_b) begin
      wr_b++;
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_b_unexpected: got %0h:%0h expected none", maddr_b, mdata_b);
      end else begin
        e = q_b.pop_front();
        chk("write_b", {maddr_b, mdata_b}, e);
      end
    end
  end

  // Input driver: fresh random digest words every cycle; bitcoin h0 tracks the next index.
  initial begin
    forever begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        h_a[j] = $urandom;
        h_b[j] = $urandom;
      end
      h_b[0] = 32'hA000_0000 + 32'(acc_b);
      if (rnd_a) valid_a = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_run_a(input logic [15:0] base);
    @(negedge clk);
    start_a = 1'b1;
    addr_a  = base;
    base_a  = base;
    acc_a   = 0;
    wr_a    = 0;
    @(negedge clk);
    start_a = 1'b0;
    addr_a  = 16'($urandom);
  endtask

  task automatic wait_done_a(input int limit);
    int n;
    n = 0;
    while (!done_a && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_a_timeout", 48'(done_a), 48'd1);
    @(negedge clk);
    #1;
    chk("run_a_accepted", 48'(acc_a), 48'(NA));
    chk("run_a_writes", 48'(wr_a), 48'(NA * WA));
    chk("run_a_queue_empty", 48'(q_a.size()), 48'd0);
  endtask

  initial begin
    int n, web;
    reset_n = 1'b0;
    start_a = 1'b0; valid_a = 1'b0; addr_a = '0;
    start_b = 1'b0; valid_b = 1'b0; addr_b = '0;
    base_a = '0; base_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 48'(done_a), 48'd1);
    chk("rst_ready", 48'(ready_a), 48'd0);
    chk("rst_we", 48'(we_a), 48'd0);
    chk("rst_addr_data", {maddr_a, mdata_a}, 48'd0);
    chk("rst_done_b", 48'(done_b), 48'd1);
    reset_n = 1'b1;

    // Cycle-accurate backpressure run, with a start pulse during RUN that must be ignored.
    valid_a = 1'b1;
    start_run_a(16'h1000);
    for (int k = 0; k <= 52; k++) begin
      case (k)
        0:  begin chk("bp_done_fall", 48'(done_a), 48'd0); chk("bp_ready_s0", 48'(ready_a), 48'd1); end
        1:  chk("bp_we_s1", 48'(we_a), 48'd0);
        2:  chk("bp_we_s2", 48'(we_a), 48'd1);
        3:  chk("bp_ready_s3", 48'(ready_a), 48'd1);
        4:  chk("bp_ready_full", 48'(ready_a), 48'd0);
        8:  chk("bp_ready_no_popthrough", 48'(ready_a), 48'd0);
        9:  chk("bp_ready_after_pop", 48'(ready_a), 48'd1);
        10: chk("bp_ready_s10", 48'(ready_a), 48'd0);
        17: chk("bp_ready_after_pop2", 48'(ready_a), 48'd1);
        18: chk("bp_ready_limit", 48'(ready_a), 48'd0);
        49: chk("bp_done_s49", 48'(done_a), 48'd0);
        50: begin chk("bp_done_s50", 48'(done_a), 48'd1); chk("bp_we_s50", 48'(we_a), 48'd0); end
        default: ;
      endcase
      start_a = (k == 5);
      addr_a  = (k == 5) ? 16'h0300 : addr_a;
      @(negedge clk);
    end
    #1;
    chk("bp_accepted", 48'(acc_a), 48'(NA));
    chk("bp_writes", 48'(wr_a), 48'(NA * WA));
    chk("bp_queue_empty", 48'(q_a.size()), 48'd0);

    // Address wrap and further randomized runs with bursty in_valid.
    rnd_a = 1'b1;
    start_run_a(16'hFFFE);
    wait_done_a(500);
    for (int r = 0; r < 3; r++) begin
      start_run_a(16'($urandom));
      wait_done_a(500);
    end

    // Reset after word 3 of digest 0, then restart at a new base.
    rnd_a = 1'b0;
    valid_a = 1'b1;
    start_run_a(16'h2000);
    n = 0;
    while (wr_a < 4 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_write_reached", 48'(wr_a), 48'd4);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 48'(we_a), 48'd0);
    chk("mid_rst_addr", 48'(maddr_a), 48'd0);
    chk("mid_rst_data", 48'(mdata_a), 48'd0);
    chk("mid_rst_done", 48'(done_a), 48'd1);
    chk("mid_rst_ready", 48'(ready_a), 48'd0);
    q_a.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rnd_a = 1'b1;
    start_run_a(16'h4000);
    wait_done_a(500);
    rnd_a = 1'b0;
    valid_a = 1'b0;

    // Bitcoin mode: one word per digest, back-to-back when inputs are pre-supplied.
    @(negedge clk);
    start_b = 1'b1; addr_b = 16'h0200; base_b = 16'h0200; acc_b = 0; wr_b = 0; valid_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    web = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k >= 2 && k <= 17 && we_b) web++;
      if (k == 17) chk("btc_done_s17", 48'(done_b), 48'd0);
      if (k == 18) chk("btc_done_s18", 48'(done_b), 48'd1);
      @(negedge clk);
    end
    #1;
    chk("btc_back_to_back", 48'(web), 48'd16);
    chk("btc_writes", 48'(wr_b), 48'(NB));
    chk("btc_accepted", 48'(acc_b), 48'(NB));
    chk("btc_queue_empty", 48'(q_b.size()), 48'd0);
    valid_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
